// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program loader with checksum and CPU reset hold
// Accepts LEN, payload, SUM; writes payload to program memory and releases the CPU on a good frame.
module prog_loader #(
  parameter logic [7:0] BASE  = 8'h00,
  parameter bit         CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       resetBar,
  input  logic       inValid,
  input  logic [7:0] inByte,
  output logic       inReady,
  output logic [7:0] progAddr,
  output logic [7:0] progData,
  output logic       progWriteBar,
  output logic       cpuResetBar,
  output logic       loadDone,
  output logic       loadError
);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_SUM,
    ST_DONE
  } state_t;

  state_t     r_state;
  logic [8:0] r_len;
  logic [8:0] r_count;
  logic [7:0] r_sum;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_wr_bar;
  logic       r_cpu_rst_bar;
  logic       r_done;
  logic       r_err;

  logic       w_xfer;
  logic [7:0] w_sum_next;
  logic       w_good;
  logic [8:0] w_count_inc;

  // Ready depends only on state (and reset), never on inValid/inByte.
  assign inReady     = resetBar & ((r_state == ST_LEN) | (r_state == ST_DATA) | (r_state == ST_SUM));
  assign w_xfer      = inValid & inReady;
  assign w_sum_next  = r_sum + inByte;
  assign w_good      = (w_sum_next == 8'h00) || !CHECK;
  assign w_count_inc = r_count + 9'd1;

  assign progAddr     = r_addr;
  assign progData     = r_data;
  assign progWriteBar = r_wr_bar;
  assign cpuResetBar  = r_cpu_rst_bar;
  assign loadDone     = r_done;
  assign loadError    = r_err;

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_state       <= ST_LEN;
      r_len         <= 9'd0;
      r_count       <= 9'd0;
      r_sum         <= 8'h00;
      r_addr        <= BASE;
      r_data        <= 8'h00;
      r_wr_bar      <= 1'b1;
      r_cpu_rst_bar <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wr_bar <= 1'b1;
      case (r_state)
        ST_LEN: begin
          if (w_xfer) begin
            r_len   <= (inByte == 8'h00) ? 9'd256 : {1'b0, inByte};
            r_sum   <= inByte;
            r_count <= 9'd0;
            r_err   <= 1'b0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_data   <= inByte;
            r_sum    <= w_sum_next;
            r_addr   <= BASE + r_count[7:0];
            r_wr_bar <= 1'b0;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_count <= w_count_inc;
          r_state <= (w_count_inc == r_len) ? ST_SUM : ST_DATA;
        end
        ST_SUM: begin
          if (w_xfer) begin
            r_sum <= w_sum_next;
            if (w_good) begin
              r_done        <= 1'b1;
              r_cpu_rst_bar <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_LEN;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_LEN;
        end
      endcase
    end
  end

endmodule
